// File: rtl/div_pkg.sv
// Shared definitions for the OpenMIPS divider: widths, FSM encoding, handshake levels, opcodes.
package div_pkg;

   localparam int unsigned RegWidth       = 32;
   localparam int unsigned DoubleRegWidth = 64;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
   localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

   function automatic logic [RegWidth-1:0] cond_neg(logic [RegWidth-1:0] v, logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_if.sv
// Handshake bundle between the execute stage (master) and the divider (slave).
interface div_if;
   import div_pkg::*;

   logic                      signed_div_i;
   logic [RegWidth-1:0]       opdata1_i;
   logic [RegWidth-1:0]       opdata2_i;
   logic                      start_i;
   logic                      annul_i;
   logic [DoubleRegWidth-1:0] result_o;
   logic                      ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from {rem, next dividend bit}.
module div_step
   import div_pkg::*;
(
   input  logic [RegWidth-1:0] rem,
   input  logic                dvd_msb,
   input  logic [RegWidth-1:0] divisor,
   output logic [RegWidth-1:0] rem_next,
   output logic                q_bit
);

   logic [RegWidth:0]   upper;
   logic [RegWidth-1:0] diff;

   // A non-negative 33-bit difference always fits in 32 bits because rem < divisor.
   always_comb begin
      upper    = {rem, dvd_msb};
      q_bit    = (upper >= {1'b0, divisor});
      diff     = upper[RegWidth-1:0] - divisor;
      rem_next = q_bit ? diff : upper[RegWidth-1:0];
   end

endmodule

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module div
   import div_pkg::*;
(
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);

   div_state_e                state_q, state_d;
   logic [4:0]                cnt_q, cnt_d;
   logic [RegWidth-1:0]       dvd_q, dvd_d;
   logic [RegWidth-1:0]       rem_q, rem_d;
   logic [RegWidth-1:0]       dvs_q, dvs_d;
   logic                      neg_quot_q, neg_quot_d;
   logic                      neg_rem_q, neg_rem_d;
   logic [DoubleRegWidth-1:0] result_q, result_d;
   logic                      ready_q, ready_d;

   logic [RegWidth-1:0] rem_step;
   logic                q_bit;
   logic [RegWidth-1:0] dvd_step;

   div_step u_step (
      .rem      (rem_q),
      .dvd_msb  (dvd_q[RegWidth-1]),
      .divisor  (dvs_q),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   assign dvd_step = {dvd_q[RegWidth-2:0], q_bit};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         DivFree: begin
            if (bus.start_i == DivStart && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d    = DivOn;
                  cnt_d      = '0;
                  rem_d      = '0;
                  dvd_d      = cond_neg(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[31]);
                  dvs_d      = cond_neg(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[31]);
                  neg_quot_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                  neg_rem_d  = bus.signed_div_i & bus.opdata1_i[31];
               end
            end
         end
         DivByZero: begin
            if (bus.annul_i) begin
               state_d = DivFree;
            end else begin
               state_d  = DivEnd;
               result_d = '0;
               ready_d  = DivResultReady;
            end
         end
         DivOn: begin
            if (bus.annul_i) begin
               state_d = DivFree;
               cnt_d   = '0;
            end else begin
               rem_d = rem_step;
               dvd_d = dvd_step;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d  = DivEnd;
                  ready_d  = DivResultReady;
                  result_d = {cond_neg(rem_step, neg_rem_q), cond_neg(dvd_step, neg_quot_q)};
               end
            end
         end
         DivEnd: begin
            if (bus.start_i == DivStop) begin
               state_d  = DivFree;
               cnt_d    = '0;
               ready_d  = DivResultNotReady;
               result_d = '0;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DivFree;
         cnt_q      <= '0;
         dvd_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= DivResultNotReady;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, signed/unsigned results, divide by zero, annul and reset.
module tb_div;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   div_if bus ();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_no_ready(input string tag, input int n);
      int hits = 0;
      repeat (n) begin
         if (bus.ready_o !== 1'b0) hits++;
         tick();
      end
      check(tag, 64'(hits), 64'd0);
   endtask

   // Starts an operation in cycle 0, scrambles operands from cycle 1, then checks the
   // ready cycle, the result, the hold period and the release.
   task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                      input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_res,
                      input int hold);
      int c;
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      tick();
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      c = 1;
      while (bus.ready_o !== 1'b1 && c < 60) begin
         tick();
         c++;
      end
      check({tag, "_cycle"}, 64'(c), 64'(exp_cyc));
      check({tag, "_result"}, bus.result_o, exp_res);
      repeat (hold) begin
         tick();
         check({tag, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {exp_res[62:0], 1'b1});
      end
      bus.start_i = 1'b0;
      check({tag, "_last_ready"}, 64'(bus.ready_o), 64'd1);
      tick();
      check({tag, "_release"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
      tick();
   endtask

   initial begin
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset", {bus.result_o[62:0], bus.ready_o}, 64'd0);
      tick();

      run("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E, 5);
      run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD, 0);
      run("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, 0);
      run("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, 0);
      run("divu_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 33, 64'h00000001_7FFFFFFC, 0);
      run("div_5_0", 1'b1, 32'd5, 32'd0, 2, 64'd0, 0);
      run("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0, 0);
      run("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF, 0);

      // Annul in cycle 10 of a division
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd20;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      tick();
      repeat (9) tick();
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      expect_no_ready("annul_on", 40);
      run("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003, 0);

      // Annul while in DivByZero
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd0;
      bus.start_i   = 1'b1;
      tick();
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      expect_no_ready("annul_byzero", 10);

      // Start together with annul in DivFree is ignored
      bus.opdata1_i = 32'd8;
      bus.opdata2_i = 32'd2;
      bus.start_i   = 1'b1;
      bus.annul_i   = 1'b1;
      tick();
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      expect_no_ready("start_annul_free", 40);

      // Reset in cycle 20 of a division
      bus.opdata1_i = 32'd77;
      bus.opdata2_i = 32'd5;
      bus.start_i   = 1'b1;
      tick();
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      bus.start_i = 1'b0;
      check("reset_mid", {bus.result_o[62:0], bus.ready_o}, 64'd0);
      expect_no_ready("reset_mid_idle", 40);
      run("divu_1000_10", 1'b0, 32'd1000, 32'd10, 33, 64'h00000000_00000064, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
